// File: rtl/gesture_uart_reporter.sv
// gesture_uart_reporter: queues confirmed gesture events and sends each as a sync + payload 8N1 UART frame
module gesture_uart_reporter #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    gesture,
  input  logic                          gesture_valid,
  input  logic [3:0]                    gesture_confidence,
  input  logic                          clr_overflow,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    dropped_count,
  output logic [1:0]                    debug_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0] seq;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shreg, payload;
  logic second;
  logic pop, push, drop, bit_done;
  assign pop = state == IDLE && fifo_count != '0;
  assign push = gesture_valid && (fifo_count != FULL || pop);
  assign drop = gesture_valid && !push;
  assign bit_done = baud == LAST;
  assign debug_state = state;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {seq, gesture, gesture_confidence};
  // tx is registered from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      tx_busy <= 1'b0;
      fifo_count <= '0;
      overflow <= 1'b0;
      dropped_count <= '0;
      seq <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      baud <= '0;
      bit_idx <= '0;
      shreg <= '0;
      payload <= '0;
      second <= 1'b0;
    end else begin
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq <= seq + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && dropped_count != 8'hFF) dropped_count <= dropped_count + 1'b1;
      overflow <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
      tx <= state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
      baud <= (state == IDLE || bit_done) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (pop) begin
          payload <= mem[rd_ptr];
          shreg <= SYNC_BYTE;
          second <= 1'b0;
          tx_busy <= 1'b1;
          state <= START;
        end
        START: if (bit_done) begin
          bit_idx <= '0;
          state <= DATA;
        end
        DATA: if (bit_done) begin
          shreg <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (bit_done) begin
          if (second) begin
            state <= IDLE;
            tx_busy <= 1'b0;
          end else begin
            shreg <= payload;
            second <= 1'b1;
            state <= START;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gesture_uart_reporter.sv
// tb_gesture_uart_reporter: directed stimulus with a payload scoreboard checked by a UART line decoder
module tb_gesture_uart_reporter;
  localparam int C = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] gesture = '0;
  logic gesture_valid = 1'b0;
  logic [3:0] conf = '0;
  logic clr = 1'b0;
  logic tx, tx_busy, overflow;
  logic [$clog2(D):0] fifo_count;
  logic [7:0] dropped_count;
  logic [1:0] debug_state;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [1:0] mseq = '0;

  gesture_uart_reporter #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .gesture(gesture), .gesture_valid(gesture_valid),
    .gesture_confidence(conf), .clr_overflow(clr), .tx(tx), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overflow(overflow), .dropped_count(dropped_count),
    .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decodes 8N1 bytes off tx; the first byte of each frame must be sync, the second is scoreboarded
  initial begin
    int mb, mcnt, bidx;
    logic [7:0] rx;
    mb = 0; mcnt = 0; bidx = 0; rx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mb = 0;
        bidx = 0;
      end else if (mb == 0) begin
        if (tx === 1'b0) begin
          mb = 1;
          mcnt = 0;
        end
      end else begin
        mcnt++;
        if (mcnt % C == C / 2 && mcnt / C >= 1 && mcnt / C <= 8) rx[mcnt / C - 1] = tx;
        if (mcnt == 9 * C + C / 2) begin
          chk("stop_bit", tx, 1);
          mb = 0;
          if (bidx == 0) begin
            chk("sync_byte", rx, 8'hA5);
            bidx = 1;
          end else begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) chk("payload", rx, sb.pop_front());
            bidx = 0;
          end
        end
      end
    end
  end

  task automatic ev(input logic [1:0] g, input logic [3:0] c, input bit acc);
    gesture = g;
    conf = c;
    gesture_valid = 1'b1;
    if (acc) begin
      sb.push_back({mseq, g, c});
      mseq++;
    end
    @(negedge clk);
    gesture_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gesture_valid = 1'b0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    mseq = '0;
    rst = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int n;
    n = 0;
    while (tx_busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_busy", tx_busy, lvl);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || tx_busy !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", n < 3000, 1);
  endtask

  initial begin
    int len, gap, nd, guard;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", dropped_count, 0);
    chk("rst_state", debug_state, 0);
    rst = 1'b0;
    @(negedge clk);
    // single event: 0xA5 then 0x29
    ev(2'd2, 4'd9, 1);
    chk("t1_count_wr", fifo_count, 1);
    chk("t1_tx_wr", tx, 1);
    chk("t1_busy_wr", tx_busy, 0);
    @(negedge clk);
    chk("t1_busy_pop", tx_busy, 1);
    chk("t1_count_pop", fifo_count, 0);
    chk("t1_tx_pop", tx, 1);
    chk("t1_state_start", debug_state, 1);
    @(negedge clk);
    chk("t1_start_low", tx, 0);
    len = 2;
    while (tx_busy && len < 200) begin
      @(negedge clk);
      if (tx_busy) len++;
    end
    chk("t1_frame_len", len, 20 * C);
    chk("t1_count_end", fifo_count, 0);
    chk("t1_tx_end", tx, 1);
    chk("t1_frame_seen", sb.size(), 0);
    // three back-to-back events
    do_reset();
    ev(2'd0, 4'd1, 1);
    chk("t2_count_a", fifo_count, 1);
    ev(2'd1, 4'd2, 1);
    chk("t2_count_b", fifo_count, 1);
    ev(2'd3, 4'd15, 1);
    chk("t2_count_peak", fifo_count, 2);
    for (int f = 0; f < 2; f++) begin
      wait_busy(1'b0, 200);
      gap = 0;
      while (!tx_busy && gap < 10) begin
        gap++;
        @(negedge clk);
      end
      chk("t2_idle_gap", gap, 1);
    end
    drain();
    // overflow with queue full during a frame
    ev(2'd1, 4'd3, 1);
    @(negedge clk);
    ev(2'd0, 4'd4, 1);
    ev(2'd1, 4'd5, 1);
    ev(2'd2, 4'd6, 1);
    ev(2'd3, 4'd7, 1);
    chk("t3_count_full", fifo_count, D);
    chk("t3_ovf_clear", overflow, 0);
    ev(2'd2, 4'd2, 0);
    clr = 1'b1;
    ev(2'd1, 4'd1, 0);
    clr = 1'b0;
    chk("t3_ovf_set_wins", overflow, 1);
    chk("t3_dropped", dropped_count, 2);
    chk("t3_count_hold", fifo_count, D);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t3_ovf_cleared", overflow, 0);
    chk("t3_dropped_kept", dropped_count, 2);
    // push in the same cycle as the pop while full
    wait_busy(1'b0, 200);
    chk("t4_count_pre", fifo_count, D);
    ev(2'd3, 4'd12, 1);
    chk("t4_count_stays", fifo_count, D);
    chk("t4_no_drop", dropped_count, 2);
    chk("t4_ovf", overflow, 0);
    drain();
    chk("t4_count_empty", fifo_count, 0);
    // reset during payload data bit 3
    do_reset();
    ev(2'd1, 4'd6, 1);
    repeat (58) @(negedge clk);
    chk("t5_state_data", debug_state, 2);
    chk("t5_bit3_low", tx, 0);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tx", tx, 1);
    chk("t5_busy", tx_busy, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_state", debug_state, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_drop", dropped_count, 0);
    rst = 1'b0;
    mseq = '0;
    @(negedge clk);
    ev(2'd1, 4'd6, 1);
    drain();
    // drop saturation
    do_reset();
    for (int i = 0; i < 5; i++) ev(2'(i), 4'(i + 8), 1);
    chk("t6_count_full", fifo_count, D);
    nd = 0;
    guard = 0;
    while (nd < 300 && guard < 3000) begin
      guard++;
      if (tx_busy) begin
        ev(2'd2, 4'd5, 0);
        nd++;
        if (nd == 254) chk("t6_pre_sat", dropped_count, 254);
      end else ev(2'd1, 4'd10, 1);
    end
    chk("t6_drops_issued", nd, 300);
    chk("t6_saturated", dropped_count, 255);
    chk("t6_ovf", overflow, 1);
    chk("t6_count", fifo_count, D);
    drain();
    chk("t6_ovf_sticky", overflow, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
